multi_cycle_ls_core: RTL and testbench
======================================

// Module: multi_cycle_ls_core
// PURPOSE
//  Multi-cycle RV32 integer core: FSM-sequenced fetch/decode/execute/memory/writeback over a shared ALU.
//  Executes LW, SW, ADDI, ADD.
//  Instruction and data memories are external, reached through req/ready handshakes, so wait states are tolerated.
//  Holds PC, IR and register file internally. Sits at the top of the datapath as the successor to the single-cycle top.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset (word aligned)
//  ADDR_W    32             memory address width driven on imem_addr/dmem_addr (low bits of byte address)
//  NREGS     32             architectural registers: 32 (RV32I) or 16 (RV32E)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  imem_req    out  1       instruction fetch request
//  imem_addr   out  ADDR_W  fetch byte address = PC[ADDR_W-1:0]
//  imem_ready  in   1       fetch complete; imem_rdata valid this cycle
//  imem_rdata  in   32      instruction word
//  dmem_req    out  1       data access request
//  dmem_we     out  1       1 = store, 0 = load
//  dmem_addr   out  ADDR_W  data byte address
//  dmem_wdata  out  32      store data (rs2)
//  dmem_ready  in   1       access complete; dmem_rdata valid this cycle (loads)
//  dmem_rdata  in   32      load data
//  trap        out  1       core halted on exception (sticky until reset)
//  trap_cause  out  2       01 illegal instr, 10 misaligned LW/SW address, 00 none
// BEHAVIOUR
//  Reset (async, while rst=1)
//   - state=FETCH, PC=RESET_PC, IR=0, all registers 0.
//   - all outputs 0 (reqs gated by rst); imem_req=1 in first cycle after release.
//   - rst mid-transaction abandons the access immediately; no register or PC update.
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP
//   - FETCH: imem_req=1, imem_addr=PC. Wait until imem_ready=1 at a rising edge; then IR<=imem_rdata -> DECODE.
//   - DECODE:
//     - illegal -> TRAP, cause 01. Illegal = any opcode/funct3/funct7 other than:
//       LW 0000011/010, SW 0100011/010, ADDI 0010011/000, ADD 0110011/000/0000000;
//       or any rs1/rs2/rd index >= NREGS.
//     - else latch A<=rs1, B<=rs2, Imm<=sign-extended I- or S-immediate -> EXEC.
//   - EXEC: ALUOut<=A+Imm (LW/SW/ADDI) or A+B (ADD), mod 2^32.
//     - LW/SW with ALUOut[1:0]!=0 -> TRAP, cause 10.
//     - LW/SW -> MEM; ADDI/ADD -> WB.
//   - MEM: dmem_req=1, dmem_addr=ALUOut, dmem_we=(SW), dmem_wdata=B.
//     - Wait for dmem_ready; SW: PC<=PC+4 -> FETCH; LW: MDR<=dmem_rdata -> WB.
//   - WB: rd<=MDR (LW) or ALUOut (ADDI/ADD); PC<=PC+4 -> FETCH.
//   - TRAP: trap=1, no requests, PC frozen at faulting instr; exit only via rst.
//  Handshake
//   - req and addr/we/wdata are stable from assertion until the edge where ready=1.
//   - req drops the cycle after ready.
//   - ready ignored when req=0; ready may be tied 1 (zero-wait).
//  Latency with zero-wait memory: LW 5 cycles, SW 4, ADDI/ADD 4; each ready-low cycle adds 1.
//  Register file
//   - x0 reads 0; writes to x0 discarded.
//   - LW to x0 still performs the dmem read.
//  PC wraps mod 2^32. RD-before-WR within an instruction is guaranteed by the FSM; no bypass needed.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - adds outputs cyc_cnt[31:0] and ret_cnt[31:0], both 0 on reset, wrapping.
//   - cyc_cnt: +1 every clock while not in TRAP.
//   - ret_cnt: +1 on each instruction's final edge (SW MEM-done, WB).
//  PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Zero-wait program:
//     - 0x00500093 addi x1,x0,5; 0x00102423 sw x1,8(x0); 0x00802103 lw x2,8(x0);
//       0x002081B3 add x3,x1,x2; 0x00302623 sw x3,12(x0)
//     - expect dmem write 5 @8, write 0xA @12; imem_addr sequence 0,4,8,12,16.
//  2. Same program, imem_ready and dmem_ready low for 3 random cycles per access
//     -> identical results; req/addr/wdata stable while waiting.
//  3. 0xFFF00093 addi x1,x0,-1, then sw x1,0(x0) -> store data 0xFFFFFFFF @0.
//  4. IR 0x00000000 at PC=4 -> trap=1, trap_cause=01, no further imem_req; then rst -> fetch from RESET_PC.
//  5. 0x00202103 lw x2,2(x0) -> trap_cause=10, dmem_req never asserted; rst during a stalled dmem_req drops req immediately.
//  6. PERF_CNT_EN, NREGS=16, test 1 program -> ret_cnt=5, cyc_cnt=21; any rd=x16 -> trap_cause=01.

Source files
------------

// File: rtl/multi_cycle_ls_core.sv
// multi_cycle_ls_core: multi-cycle RV32 core (LW/SW/ADDI/ADD) with req/ready memories.
// Optional PERF_CNT_EN adds cycle and retired-instruction counters.
module multi_cycle_ls_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int ADDR_W = 32,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              trap,
    output logic [1:0]        trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       ret_cnt
`endif
);
    localparam int RW = $clog2(NREGS);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    state_t state, state_nx;
    logic [31:0] pc, ir, a, b, imm, alu_out, mdr, alu_sum;
    logic [31:0] regs [NREGS];
    logic [1:0] cause, cause_nx;
    logic is_lw, is_sw, is_addi, is_add, mem_op, ok1, ok2, okd, legal;
    assign is_lw   = ir[6:0] == 7'b0000011 && ir[14:12] == 3'b010;
    assign is_sw   = ir[6:0] == 7'b0100011 && ir[14:12] == 3'b010;
    assign is_addi = ir[6:0] == 7'b0010011 && ir[14:12] == 3'b000;
    assign is_add  = ir[6:0] == 7'b0110011 && ir[14:12] == 3'b000 && ir[31:25] == 7'b0;
    assign mem_op  = is_lw || is_sw;
    // Only register fields the instruction actually uses are range-checked
    assign ok1 = 32'(ir[19:15]) < NREGS;
    assign ok2 = 32'(ir[24:20]) < NREGS;
    assign okd = 32'(ir[11:7]) < NREGS;
    assign legal = ((is_lw || is_addi) && ok1 && okd) || (is_sw && ok1 && ok2) || (is_add && ok1 && ok2 && okd);
    assign alu_sum = a + (is_add ? b : imm);
    always_comb begin
        state_nx = state;
        cause_nx = cause;
        case (state)
            FETCH:  state_nx = imem_ready ? DECODE : FETCH;
            DECODE: begin
                state_nx = legal ? EXEC : TRAP;
                cause_nx = legal ? cause : 2'b01;
            end
            EXEC: begin
                state_nx = (mem_op && alu_sum[1:0] != 2'b00) ? TRAP : (mem_op ? MEM : WB);
                cause_nx = (mem_op && alu_sum[1:0] != 2'b00) ? 2'b10 : cause;
            end
            MEM:    state_nx = dmem_ready ? (is_sw ? FETCH : WB) : MEM;
            WB:     state_nx = FETCH;
            default: state_nx = TRAP;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc <= RESET_PC;
            ir <= '0;
            a <= '0;
            b <= '0;
            imm <= '0;
            alu_out <= '0;
            mdr <= '0;
            cause <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
            if (state == FETCH && imem_ready) ir <= imem_rdata;
            if (state == DECODE) begin
                a <= regs[ir[15 +: RW]];
                b <= regs[ir[20 +: RW]];
                imm <= is_sw ? {{20{ir[31]}}, ir[31:25], ir[11:7]} : {{20{ir[31]}}, ir[31:20]};
            end
            if (state == EXEC) alu_out <= alu_sum;
            if (state == MEM && dmem_ready && is_lw) mdr <= dmem_rdata;
            if ((state == MEM && dmem_ready && is_sw) || state == WB) pc <= pc + 32'd4;
            if (state == WB && ir[11:7] != 5'd0) regs[ir[7 +: RW]] <= is_lw ? mdr : alu_out;
        end
    end
`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + (state != TRAP ? 32'd1 : 32'd0);
            ret_cnt <= ret_cnt + (((state == MEM && dmem_ready && is_sw) || state == WB) ? 32'd1 : 32'd0);
        end
    end
`endif
    assign imem_req   = !rst && state == FETCH;
    assign imem_addr  = rst ? '0 : pc[ADDR_W-1:0];
    assign dmem_req   = !rst && state == MEM;
    assign dmem_we    = dmem_req && is_sw;
    assign dmem_addr  = rst ? '0 : alu_out[ADDR_W-1:0];
    assign dmem_wdata = rst ? '0 : b;
    assign trap       = state == TRAP;
    assign trap_cause = cause;
endmodule

// File: tb/tb_multi_cycle_ls_core.sv
// tb_multi_cycle_ls_core: scoreboard bench; fetch/data queues hold expected accesses in order.
module tb_multi_cycle_ls_core;
`ifdef PERF_CNT_EN
    localparam int NR = 16;
    logic [31:0] cyc_cnt, ret_cnt;
`else
    localparam int NR = 32;
`endif
    logic clk = 0, rst = 1;
    logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, trap;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0] trap_cause;
    always #5 clk = ~clk;
    multi_cycle_ls_core #(.RESET_PC(32'h0), .ADDR_W(32), .NREGS(NR)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .trap(trap), .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );
    typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} acc_t;
    int checks = 0, failures = 0;
    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] fetch_q [$];
    acc_t data_q [$];
    int waits = 0, iw = 0, dw = 0, cyc = 0, dreq_cycles = 0;
    bit i_act = 0, d_act = 0;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic d_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            i_act = 0;
            imem_ready = 0;
            imem_rdata = 0;
        end else if (imem_req) begin
            if (!i_act) begin
                i_act = 1;
                iw = waits;
                i_addr = imem_addr;
            end else check("imem_addr_stable", imem_addr, i_addr);
            imem_ready = (iw == 0);
            imem_rdata = imem_ready ? imem[imem_addr[7:2]] : $urandom;
            if (iw == 0) begin
                i_act = 0;
                if (fetch_q.size() == 0) check("fetch_extra", imem_addr, 32'hFFFF_FFFF);
                else check("fetch_addr", imem_addr, fetch_q.pop_front());
            end else iw--;
        end else imem_ready = (waits > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            d_act = 0;
            dmem_ready = 0;
            dmem_rdata = 0;
        end else if (dmem_req) begin
            dreq_cycles++;
            if (!d_act) begin
                d_act = 1;
                dw = waits;
                d_addr = dmem_addr;
                d_wdata = dmem_wdata;
                d_we = dmem_we;
            end else begin
                check("dmem_addr_stable", dmem_addr, d_addr);
                check("dmem_wdata_stable", dmem_wdata, d_wdata);
                check("dmem_we_stable", 32'(dmem_we), 32'(d_we));
            end
            dmem_ready = (dw == 0);
            dmem_rdata = dmem_ready ? dmem[dmem_addr[7:2]] : $urandom;
            if (dw == 0) begin
                acc_t e;
                d_act = 0;
                if (data_q.size() == 0) check("data_extra", dmem_addr, 32'hFFFF_FFFF);
                else begin
                    e = data_q.pop_front();
                    check("dmem_we", 32'(dmem_we), 32'(e.we));
                    check("dmem_addr", dmem_addr, e.addr);
                    if (e.we) begin
                        check("dmem_wdata", dmem_wdata, e.data);
                        dmem[dmem_addr[7:2]] = dmem_wdata;
                    end
                end
            end else dw--;
        end else dmem_ready = (waits > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        waits = 0;
        fetch_q.delete();
        data_q.delete();
        dreq_cycles = 0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 0;
            dmem[i] = 0;
        end
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_imem_addr", imem_addr, 0);
`ifdef PERF_CNT_EN
        check("rst_cyc_cnt", cyc_cnt, 0);
        check("rst_ret_cnt", ret_cnt, 0);
`endif
    endtask

    task automatic run_to_trap(input string tag, input int w, input int exp_cyc, input logic [1:0] exp_cause,
                               input logic [31:0] exp_pc, input int exp_ret);
        int n = 0;
        waits = w;
        rst = 0;
        while (!trap && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_trap"}, 32'(trap), 1);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_cause"}, 32'(trap_cause), 32'(exp_cause));
        check({tag, "_fetch_left"}, fetch_q.size(), 0);
        check({tag, "_data_left"}, data_q.size(), 0);
`ifdef PERF_CNT_EN
        check({tag, "_cyc_cnt"}, cyc_cnt, exp_cyc);
        check({tag, "_ret_cnt"}, ret_cnt, exp_ret);
`else
        if (exp_ret < 0) check({tag, "_ret_arg"}, exp_ret, 0);
`endif
        repeat (4) @(negedge clk);
        check({tag, "_no_req"}, 32'(imem_req | dmem_req), 0);
        check({tag, "_pc_frozen"}, imem_addr, exp_pc);
        check({tag, "_trap_sticky"}, 32'(trap), 1);
    endtask

    task automatic load_t1();
        imem[0] = 32'h00500093;
        imem[1] = 32'h00102423;
        imem[2] = 32'h00802103;
        imem[3] = 32'h002081B3;
        imem[4] = 32'h00302623;
        fetch_q = '{0, 4, 8, 12, 16, 20};
        data_q.push_back('{1'b1, 32'd8, 32'd5});
        data_q.push_back('{1'b0, 32'd8, 32'd0});
        data_q.push_back('{1'b1, 32'd12, 32'hA});
    endtask

    initial begin
        int n;
        do_reset();
        load_t1();
        run_to_trap("zero_wait", 0, 23, 2'b01, 32'd20, 5);
        do_reset();
        load_t1();
        run_to_trap("stalled", 3, 50, 2'b01, 32'd20, 5);
        do_reset();
        imem[0] = 32'hFFF00093;
        imem[1] = 32'h00102023;
        fetch_q = '{0, 4, 8};
        data_q.push_back('{1'b1, 32'd0, 32'hFFFF_FFFF});
        run_to_trap("neg_imm", 0, 10, 2'b01, 32'd8, 2);
        do_reset();
        imem[0] = 32'h00500093;
        fetch_q = '{0, 4};
        run_to_trap("illegal_zero", 0, 6, 2'b01, 32'd4, 1);
        do_reset();
        imem[0] = 32'h00202103;
        fetch_q = '{0};
        run_to_trap("misaligned", 0, 3, 2'b10, 32'd0, 0);
        check("misaligned_no_dreq", dreq_cycles, 0);
        do_reset();
        imem[0] = 32'h00100813;
        fetch_q = (NR == 16) ? '{0} : '{0, 4};
        run_to_trap("rd_x16", 0, (NR == 16) ? 2 : 6, 2'b01, (NR == 16) ? 32'd0 : 32'd4, (NR == 16) ? 0 : 1);
        do_reset();
        imem[0] = 32'h00102423;
        fetch_q = '{0};
        data_q.push_back('{1'b1, 32'd8, 32'd0});
        waits = 20;
        rst = 0;
        n = 0;
        while (!dmem_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_dreq_seen", 32'(dmem_req), 1);
        #2 rst = 1;
        #1 check("rst_drops_dreq", 32'(dmem_req), 0);
        check("rst_drops_we", 32'(dmem_we), 0);
        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
